// File: rtl/qpel_cost_select.sv
// qpel_cost_select
//   Quarter-pel candidate selection for one 4x4 block. Each accepted sample
//   adds |quat[k]-cur_pix| into nine parallel SAD accumulators. After NPIX
//   samples a nine-cycle sequential compare picks the cheapest candidate.
//   The centre candidate wins ties, and otherwise the lowest index wins.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | after reset, waiting for start
//   ACCUM | accepting samples, in_ready high
//   CMP   | walking candidate index 0..8, one per cycle
//   DONE  | result held on outputs until the next start
//
// Ports
//   clk, rst_n        system clock, async active-low reset
//   start             begins a block (honoured in IDLE/DONE only)
//   valid_in/in_ready sample handshake
//   cur_pix           current-frame pixel
//   quat              nine 8-bit candidates, quat[8k+7:8k] = candidate k
//   busy              high in ACCUM or CMP
//   done              one-cycle pulse when the result becomes valid
//   best_q/best_sad   winning index and its SAD
//   dx, dy            two's complement offsets of the winner (-1..1)
module qpel_cost_select #(
    parameter int NPIX  = 16,
    parameter int SAD_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             valid_in,
    output logic             in_ready,
    input  logic [7:0]       cur_pix,
    input  logic [71:0]      quat,
    output logic             busy,
    output logic             done,
    output logic [3:0]       best_q,
    output logic [SAD_W-1:0] best_sad,
    output logic [1:0]       dx,
    output logic [1:0]       dy
);

    localparam int CNT_W = $clog2(NPIX + 1);

    typedef enum logic [1:0] {IDLE, ACCUM, CMP, DONE} state_t;

    state_t                  state_q, state_d;
    logic [8:0][SAD_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [3:0]              idx_q, idx_d;
    logic [3:0]              run_idx_q, run_idx_d;
    logic [SAD_W-1:0]        run_sad_q, run_sad_d;
    logic [3:0]              out_idx_q, out_idx_d;
    logic [SAD_W-1:0]        out_sad_q, out_sad_d;
    logic [1:0]              out_dx_q, out_dx_d;
    logic [1:0]              out_dy_q, out_dy_d;
    logic                    done_q, done_d;

    logic [8:0][7:0]         ad;
    logic [SAD_W-1:0]        cand_sad;

    // {dx, dy} for a candidate index: column-1 and row-1 of the 3x3 grid.
    function automatic logic [3:0] qpel_offset(input logic [3:0] idx);
        logic [3:0] off;
        case (idx)
            4'd0:    off = 4'b11_11;
            4'd1:    off = 4'b00_11;
            4'd2:    off = 4'b01_11;
            4'd3:    off = 4'b11_00;
            4'd5:    off = 4'b01_00;
            4'd6:    off = 4'b11_01;
            4'd7:    off = 4'b00_01;
            4'd8:    off = 4'b01_01;
            default: off = 4'b00_00;
        endcase
        return off;
    endfunction

    always_comb begin
        for (int k = 0; k < 9; k++) begin
            if (quat[8*k +: 8] >= cur_pix) ad[k] = quat[8*k +: 8] - cur_pix;
            else                           ad[k] = cur_pix - quat[8*k +: 8];
        end
    end

    always_comb begin
        cand_sad = '0;
        for (int k = 0; k < 9; k++) begin
            if (idx_q == 4'(k)) cand_sad = acc_q[k];
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        run_idx_d = run_idx_q;
        run_sad_d = run_sad_q;
        out_idx_d = out_idx_q;
        out_sad_d = out_sad_q;
        out_dx_d  = out_dx_q;
        out_dy_d  = out_dy_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (valid_in) begin
                    for (int k = 0; k < 9; k++) begin
                        acc_d[k] = acc_q[k] + SAD_W'(ad[k]);
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(NPIX - 1)) begin
                        state_d   = CMP;
                        idx_d     = '0;
                        // Seed with the centre so it wins every tie.
                        run_idx_d = 4'd4;
                        run_sad_d = acc_q[4] + SAD_W'(ad[4]);
                    end
                end
            end
            CMP: begin
                if (idx_q != 4'd4 && cand_sad < run_sad_q) begin
                    run_idx_d = idx_q;
                    run_sad_d = cand_sad;
                end
                idx_d = idx_q + 1'b1;
                if (idx_q == 4'd8) begin
                    state_d              = DONE;
                    out_idx_d            = run_idx_d;
                    out_sad_d            = run_sad_d;
                    {out_dx_d, out_dy_d} = qpel_offset(run_idx_d);
                    done_d               = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            idx_q     <= '0;
            run_idx_q <= 4'd4;
            run_sad_q <= '0;
            out_idx_q <= 4'd4;
            out_sad_q <= '0;
            out_dx_q  <= '0;
            out_dy_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            run_idx_q <= run_idx_d;
            run_sad_q <= run_sad_d;
            out_idx_q <= out_idx_d;
            out_sad_q <= out_sad_d;
            out_dx_q  <= out_dx_d;
            out_dy_q  <= out_dy_d;
            done_q    <= done_d;
        end
    end

    assign in_ready = (state_q == ACCUM);
    assign busy     = (state_q == ACCUM) || (state_q == CMP);
    assign done     = done_q;
    assign best_q   = out_idx_q;
    assign best_sad = out_sad_q;
    assign dx       = out_dx_q;
    assign dy       = out_dy_q;

endmodule

// File: tb/tb_qpel_cost_select.sv
module tb_qpel_cost_select;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        valid_in;
    logic        in_ready;
    logic [7:0]  cur_pix;
    logic [71:0] quat;
    logic        busy;
    logic        done;
    logic [3:0]  best_q;
    logic [11:0] best_sad;
    logic [1:0]  dx;
    logic [1:0]  dy;

    qpel_cost_select #(.NPIX(16), .SAD_W(12)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .valid_in (valid_in),
        .in_ready (in_ready),
        .cur_pix  (cur_pix),
        .quat     (quat),
        .busy     (busy),
        .done     (done),
        .best_q   (best_q),
        .best_sad (best_sad),
        .dx       (dx),
        .dy       (dy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  idx;
        logic [11:0] sad;
        logic [1:0]  dx;
        logic [1:0]  dy;
        int          acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   n_tests  = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   done_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("best_q",   32'(best_q),   32'(e.idx));
                chk("best_sad", 32'(best_sad), 32'(e.sad));
                chk("dx",       32'(dx),       32'(e.dx));
                chk("dy",       32'(dy),       32'(e.dy));
                chk("latency",  32'(cyc - e.acc_cyc), 32'd9);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [71:0] mkq(input logic [7:0] q0, q1, q2, q3, q4,
                                        q5, q6, q7, q8);
        return {q8, q7, q6, q5, q4, q3, q2, q1, q0};
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"},     32'(busy),     32'd0);
        chk({tag, "_done"},     32'(done),     32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_best_q"},   32'(best_q),   32'd4);
        chk({tag, "_best_sad"}, 32'(best_sad), 32'd0);
        chk({tag, "_dx"},       32'(dx),       32'd0);
        chk({tag, "_dy"},       32'(dy),       32'd0);
    endtask

    // Issues start (with a poisoned sample that must be ignored), then 16
    // samples. Optional random gaps with a stray start inside ACCUM, and a
    // stray start in the first CMP cycle.
    task automatic run_block(input logic [7:0] cp, input logic [71:0] q,
                             input logic [3:0] e_idx, input logic [11:0] e_sad,
                             input logic [1:0] e_dx, input logic [1:0] e_dy,
                             input bit gaps, input bit stray);
        int   d0;
        int   ng;
        exp_t e;
        start    = 1'b1;
        valid_in = 1'b1;
        cur_pix  = 8'd0;
        quat     = {9{8'hFF}};
        tick();
        start    = 1'b0;
        valid_in = 1'b0;
        chk("busy_accum",     32'(busy),     32'd1);
        chk("in_ready_accum", 32'(in_ready), 32'd1);
        for (int i = 0; i < 16; i++) begin
            ng = gaps ? int'($urandom_range(0, 2)) : 0;
            if (stray && i == 5) ng = ng + 1;
            for (int g = 0; g < ng; g++) begin
                valid_in = 1'b0;
                cur_pix  = 8'd0;
                quat     = {9{8'hFF}};
                start    = (stray && i == 5 && g == 0);
                tick();
                start = 1'b0;
            end
            cur_pix  = cp;
            quat     = q;
            valid_in = 1'b1;
            if (i == 15) begin
                e.idx     = e_idx;
                e.sad     = e_sad;
                e.dx      = e_dx;
                e.dy      = e_dy;
                e.acc_cyc = cyc + 1;
                sb.push_back(e);
            end
            tick();
        end
        valid_in = 1'b0;
        if (stray) begin
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        d0 = done_cnt;
        for (int t = 0; t < 40 && done_cnt == d0; t++) tick();
        if (done_cnt == d0) begin
            chk("done_timeout", 32'd1, 32'd0);
            sb.delete();
        end
        repeat (3) tick();
        chk("hold_best_q",   32'(best_q),   32'(e_idx));
        chk("hold_best_sad", 32'(best_sad), 32'(e_sad));
        chk("busy_done",     32'(busy),     32'd0);
        chk("ready_done",    32'(in_ready), 32'd0);
    endtask

    logic [71:0] q_ramp, q_flat, q_sat, q_tie;

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        valid_in = 1'b0;
        cur_pix  = 8'd0;
        quat     = '0;
        q_ramp = mkq(8'd100, 8'd101, 8'd102, 8'd103, 8'd110,
                     8'd105, 8'd106, 8'd107, 8'd108);
        q_flat = mkq(8'd77, 8'd77, 8'd77, 8'd77, 8'd77,
                     8'd77, 8'd77, 8'd77, 8'd77);
        q_sat  = mkq(8'd255, 8'd255, 8'd255, 8'd255, 8'd255,
                     8'd255, 8'd255, 8'd254, 8'd255);
        q_tie  = mkq(8'd53, 8'd51, 8'd53, 8'd53, 8'd52,
                     8'd53, 8'd51, 8'd53, 8'd53);
        #12;
        check_reset_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) tick();
        chk("idle_busy",  32'(busy),     32'd0);
        chk("idle_ready", 32'(in_ready), 32'd0);

        run_block(8'd100, q_ramp, 4'd0, 12'd0,    2'b11, 2'b11, 1'b0, 1'b0);
        run_block(8'd77,  q_flat, 4'd4, 12'd0,    2'b00, 2'b00, 1'b0, 1'b0);
        run_block(8'd0,   q_sat,  4'd7, 12'd4064, 2'b00, 2'b01, 1'b0, 1'b0);
        run_block(8'd50,  q_tie,  4'd1, 12'd16,   2'b00, 2'b11, 1'b0, 1'b0);
        run_block(8'd100, q_ramp, 4'd0, 12'd0,    2'b11, 2'b11, 1'b1, 1'b1);

        // Reset in the middle of ACCUM: partial block discarded, no done.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cur_pix  = 8'd10;
            quat     = q_flat;
            valid_in = 1'b1;
            tick();
        end
        valid_in = 1'b0;
        rst_n    = 1'b0;
        #2;
        check_reset_outputs("midrst");
        repeat (3) tick();
        check_reset_outputs("midrst_hold");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) tick();
        chk("post_rst_idle", 32'(busy), 32'd0);
        chk("post_rst_best", 32'(best_q), 32'd4);

        run_block(8'd0, q_sat, 4'd7, 12'd4064, 2'b00, 2'b01, 1'b0, 1'b0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/qpel_cost_select.md
QPEL_COST_SELECT -- requirements
Module: qpel_cost_select

Interface
REQ-001 The block SHALL have parameter NPIX, default 16, meaning the number of pixel samples per block (4x4).
REQ-002 The block SHALL have parameter SAD_W, default 12, meaning the accumulator width; it SHALL hold NPIX*255 without overflow.
REQ-003 The block SHALL have port clk  input  1  meaning the single system clock, with all state changing on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  meaning the reset; reset is asynchronous and active-low.
REQ-005 The block SHALL have port start  input  1  meaning a pulse that begins a new block.
REQ-006 The block SHALL have port valid_in  input  1  meaning the sample on cur_pix and quat is valid.
REQ-007 The block SHALL have port in_ready  output  1  meaning a sample is accepted when valid_in and in_ready are both high.
REQ-008 The block SHALL have port cur_pix  input  8  meaning the current-frame pixel.
REQ-009 The block SHALL have port quat  input  9x8  meaning the nine quarter-pel candidates for cur_pix, indexed 0..8 raster-wise around the centre index 4.
REQ-010 The block SHALL have port busy  output  1  meaning the FSM is not IDLE and not DONE.
REQ-011 The block SHALL have port done  output  1  meaning a one-cycle pulse that marks the result as valid.
REQ-012 The block SHALL have port best_q  output  4  meaning the winning candidate index 0..8.
REQ-013 The block SHALL have port best_sad  output  SAD_W  meaning the SAD of the winner.
REQ-014 The block SHALL have ports dx and dy  output  2 each, signed  meaning the quarter-pel offset of the winner.

Function
REQ-015 The FSM SHALL have four states: IDLE, ACCUM, CMP and DONE.
REQ-016 A start pulse seen in IDLE or DONE SHALL clear all nine accumulators and the pixel counter, and SHALL move the FSM to ACCUM on that edge.
REQ-017 A start pulse seen in ACCUM or CMP SHALL be ignored.
REQ-018 in_ready SHALL be high only while the FSM is in ACCUM.
REQ-019 valid_in outside ACCUM SHALL be ignored, and valid_in in the same cycle as an accepted start SHALL be ignored.
REQ-020 For each accepted sample, the block SHALL add |quat[k]-cur_pix| (8-bit unsigned absolute difference) to accumulator k for every k in 0..8, all in parallel within one cycle.
REQ-021 Gaps in valid_in (valid_in low while in ACCUM) SHALL stall accumulation without any other state change.
REQ-022 The pixel counter SHALL increment once per accepted sample.
REQ-023 On the edge that accepts sample number NPIX, the FSM SHALL move to CMP with the compare index set to 0.
REQ-024 On entering CMP, the running best SHALL be initialised to index 4 with the SAD of accumulator 4.
REQ-025 CMP SHALL take exactly one cycle per index 0..8 (9 cycles); at each index k not equal to 4, candidate k SHALL replace the running best only if its SAD is strictly less; index 4 SHALL be a no-op cycle.
REQ-026 Tie-break SHALL therefore resolve in favour of the centre candidate first, and otherwise the lowest index.
REQ-027 After the index-8 cycle the FSM SHALL move to DONE, and best_q, best_sad, dx and dy SHALL be registered on that same edge.
REQ-028 done SHALL be high for exactly the one cycle following the edge that enters DONE.
REQ-029 Latency SHALL be 9 clock edges from the edge that accepts the last sample to the edge that raises done.
REQ-030 The block SHALL remain in DONE holding its outputs until start is seen; DONE SHALL NOT time out back to IDLE.
REQ-031 The offsets SHALL be computed as dx = (best_q mod 3) - 1 and dy = (best_q div 3) - 1.
REQ-032 The outputs SHALL be stable between done pulses and SHALL change only on entry to DONE or on reset.

Reset
REQ-033 When rst_n is low, the block SHALL asynchronously force the FSM to IDLE and clear the accumulators, the pixel counter and the compare index.
REQ-034 While rst_n is low, the outputs SHALL be busy=0, done=0, in_ready=0, best_q=4, best_sad=0, dx=0 and dy=0.
REQ-035 A reset that arrives in the middle of ACCUM or CMP SHALL discard the partial block and produce no done pulse.
REQ-036 After rst_n is released, the block SHALL remain in IDLE until start is seen.

Verification
REQ-037 Scenario: cur_pix=100 and quat[k]=100+k for k not equal to 4, quat[4]=110, applied for 16 samples -> best_q=0, best_sad=0, dx=-1, dy=-1, with done exactly 9 edges after the last sample.
REQ-038 Scenario: all candidates equal to cur_pix for 16 samples -> best_q=4, best_sad=0, dx=0, dy=0 (centre wins the tie).
REQ-039 Scenario: cur_pix=0, all quat=255 except quat[7]=254 -> best_q=7, best_sad=4064, dx=0, dy=1, with no overflow.
REQ-040 Scenario: quat[4]=cur_pix+2, quat[1]=quat[6]=cur_pix+1, all others cur_pix+3 -> best_q=1, best_sad=16 (lowest index wins the tie).
REQ-041 Scenario: valid_in with random gaps, a start pulse issued in ACCUM, and another issued in CMP -> the result is identical to the gap-free run and both start pulses have no effect.
REQ-042 Scenario: rst_n asserted after 8 samples -> all outputs at their reset values and no done pulse; a following clean block then gives correct results.
